// File: rtl/izh_pkg.sv
// Shared types and fixed-point constants for the Izhikevich neuron scheduler.
package izh_pkg;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Quadratic term: 0.04*v^2 ~= (v*v*41) >>> 10
   localparam int IZ_SQ_MUL = 41;
   localparam int IZ_SQ_SHR = 10;
   // Linear and constant terms of dv
   localparam int IZ_LIN    = 5;
   localparam int IZ_CONST  = 140;
   // Recovery coupling b ~= 13/64
   localparam int IZ_B_MUL  = 13;
   localparam int IZ_B_SHR  = 6;
   // Recovery rate a ~= 1/64
   localparam int IZ_A_SHR  = 6;

   // Clamp a 32-bit signed intermediate into the 16-bit state range
   function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
      if (x > 32'sd32767) begin
         return 16'sh7FFF;
      end else if (x < -32'sd32768) begin
         return 16'sh8000;
      end else begin
         return $signed(x[15:0]);
      end
   endfunction

endpackage

// File: rtl/izh_step.sv
// Combinational Izhikevich update for one neuron: (v, u, I) -> written-back (v, u) and fired flag.
module izh_step
   import izh_pkg::*;
#(
   parameter int V_PEAK = 30,
   parameter int C_RST  = -65,
   parameter int D_INC  = 8
) (
   input  logic signed [15:0] i_v,
   input  logic signed [15:0] i_u,
   input  logic signed [15:0] i_i,
   output logic signed [15:0] o_v_w,
   output logic signed [15:0] o_u_w,
   output logic               o_fired
);

   logic signed [31:0] w_v;
   logic signed [31:0] w_u;
   logic signed [31:0] w_i;
   logic signed [31:0] w_dv;
   logic signed [31:0] w_du;
   logic signed [15:0] w_v_n;
   logic signed [15:0] w_u_n;

   // Sign-extend operands; every intermediate is 32-bit and wraps like plain integer math
   assign w_v = {{16{i_v[15]}}, i_v};
   assign w_u = {{16{i_u[15]}}, i_u};
   assign w_i = {{16{i_i[15]}}, i_i};

   assign w_dv = ((w_v * w_v * IZ_SQ_MUL) >>> IZ_SQ_SHR) + (IZ_LIN * w_v) + IZ_CONST - w_u + w_i;
   // Recovery update uses the old v, not v_next
   assign w_du = (((w_v * IZ_B_MUL) >>> IZ_B_SHR) - w_u) >>> IZ_A_SHR;

   assign w_v_n = sat16(w_v + w_dv);
   assign w_u_n = sat16(w_u + w_du);

   // Threshold is applied after saturation so a clamped v still counts as a spike
   assign o_fired = (int'(w_v_n) >= V_PEAK);
   assign o_v_w   = o_fired ? 16'(C_RST) : w_v_n;
   assign o_u_w   = o_fired ? sat16(int'(w_u_n) + D_INC) : w_u_n;

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Izhikevich neuron scheduler: one shared update core swept across all neurons once per tick.
module izh_neuron_scheduler
   import izh_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int IDX_W     = 3,
   parameter int V_PEAK    = 30,
   parameter int C_RST     = -65,
   parameter int D_INC     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [16*N_NEURONS-1:0] I_bus,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun,
   output logic                    spike_valid,
   output logic [IDX_W-1:0]        spike_idx,
   output logic [N_NEURONS-1:0]    spike_mask,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic signed [15:0]      rd_v,
   output logic signed [15:0]      rd_u
);

   // Reset u is b*v with truncating division, giving -13 for v=-65
   localparam int               U_RST    = (C_RST * IZ_B_MUL) / (1 << IZ_B_SHR);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   state_t                 r_state;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_overrun;
   logic [N_NEURONS-1:0]   r_mask_acc;
   logic [N_NEURONS-1:0]   r_spike_mask;
   logic signed [15:0]     r_op_v;
   logic signed [15:0]     r_op_u;
   logic signed [15:0]     r_op_i;
   logic signed [15:0]     r_v    [N_NEURONS];
   logic signed [15:0]     r_u    [N_NEURONS];
   logic signed [15:0]     r_ibuf [N_NEURONS];
   logic signed [15:0]     r_rd_v;
   logic signed [15:0]     r_rd_u;

   logic signed [15:0]     w_v_w;
   logic signed [15:0]     w_u_w;
   logic                   w_fired;
   logic                   w_write_en;
   logic                   w_last;
   logic [N_NEURONS-1:0]   w_hit;
   logic [N_NEURONS-1:0]   w_mask_next;

   izh_step #(
      .V_PEAK (V_PEAK),
      .C_RST  (C_RST),
      .D_INC  (D_INC)
   ) u_step (
      .i_v     (r_op_v),
      .i_u     (r_op_u),
      .i_i     (r_op_i),
      .o_v_w   (w_v_w),
      .o_u_w   (w_u_w),
      .o_fired (w_fired)
   );

   // A reset arriving during WRITE suppresses both the write-back and the spike
   assign w_write_en = (r_state == WRITE) && !reset;
   assign w_last     = (r_idx == LAST_IDX);

   for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_hit
      assign w_hit[gi] = w_fired && (r_idx == IDX_W'(gi));
   end

   assign w_mask_next = r_mask_acc | w_hit;

   assign spike_valid = w_write_en && w_fired;
   assign spike_idx   = spike_valid ? r_idx : '0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign overrun     = r_overrun;
   assign spike_mask  = r_spike_mask;
   assign rd_v        = r_rd_v;
   assign rd_u        = r_rd_u;

   // Sweep sequencer: index walk, operand fetch, done pulse, mask publish, overrun flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_overrun    <= 1'b0;
         r_mask_acc   <= '0;
         r_spike_mask <= '0;
         r_op_v       <= '0;
         r_op_u       <= '0;
         r_op_i       <= '0;
      end else begin
         r_done <= 1'b0;
         if (tick && r_busy) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (tick) begin
                  r_state    <= FETCH;
                  r_idx      <= '0;
                  r_busy     <= 1'b1;
                  r_mask_acc <= '0;
               end
            end
            FETCH: begin
               r_op_v  <= r_v[r_idx];
               r_op_u  <= r_u[r_idx];
               r_op_i  <= r_ibuf[r_idx];
               r_state <= WRITE;
            end
            WRITE: begin
               if (w_last) begin
                  r_state      <= IDLE;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_spike_mask <= w_mask_next;
                  r_mask_acc   <= '0;
               end else begin
                  r_state    <= FETCH;
                  r_idx      <= r_idx + 1'b1;
                  r_mask_acc <= w_mask_next;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Per-neuron state array: reset to rest potential, written back once per neuron per sweep
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            r_v[k] <= 16'(C_RST);
            r_u[k] <= 16'(U_RST);
         end
      end else if (w_write_en) begin
         r_v[r_idx] <= w_v_w;
         r_u[r_idx] <= w_u_w;
      end
   end

   // Input current snapshot taken on tick acceptance so I_bus may change mid-sweep
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            r_ibuf[k] <= '0;
         end
      end else if ((r_state == IDLE) && tick) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            r_ibuf[k] <= $signed(I_bus[16*k +: 16]);
         end
      end
   end

   // Registered readout port: returns array contents as of the previous cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_v <= '0;
         r_rd_u <= '0;
      end else if (int'(rd_idx) < N_NEURONS) begin
         r_rd_v <= r_v[rd_idx];
         r_rd_u <= r_u[rd_idx];
      end else begin
         r_rd_v <= '0;
         r_rd_u <= '0;
      end
   end

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Self-checking bench for izh_neuron_scheduler: vector table, corner sequences, randomized sweeps.
module tb_izh_neuron_scheduler;

   localparam int N  = 8;
   localparam int IW = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  tick;
   logic [16*N-1:0]       I_bus;
   logic                  busy;
   logic                  done;
   logic                  overrun;
   logic                  spike_valid;
   logic [IW-1:0]         spike_idx;
   logic [N-1:0]          spike_mask;
   logic [IW-1:0]         rd_idx;
   logic signed [15:0]    rd_v;
   logic signed [15:0]    rd_u;

   always #5 clk = ~clk;

   izh_neuron_scheduler #(
      .N_NEURONS (N),
      .IDX_W     (IW),
      .V_PEAK    (30),
      .C_RST     (-65),
      .D_INC     (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .I_bus       (I_bus),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .spike_valid (spike_valid),
      .spike_idx   (spike_idx),
      .spike_mask  (spike_mask),
      .rd_idx      (rd_idx),
      .rd_v        (rd_v),
      .rd_u        (rd_u)
   );

   int n_checks;
   int n_errors;
   int mv [N];
   int mu [N];
   int cur_i [N];
   logic [N-1:0] prev_mask;
   int sweep_no;

   typedef struct {
      int         i_base;
      int         hot;
      int         i_hot;
      logic [7:0] exp_mask;
      int         chk_idx;
      int         exp_v;
      int         exp_u;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sat(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Reference update written straight from the neuron equations with integer arithmetic
   task automatic model_step(input int v, input int u, input int i, output int vw, output int uw, output bit f);
      int dv, du, vn, un;
      dv = ((v * v * 41) >>> 10) + 5 * v + 140 - u + i;
      vn = sat(v + dv);
      du = (((v * 13) >>> 6) - u) >>> 6;
      un = sat(u + du);
      f  = (vn >= 30);
      vw = f ? -65 : vn;
      uw = f ? sat(un + 8) : un;
   endtask

   task automatic set_ibus();
      for (int k = 0; k < N; k++) I_bus[16*k +: 16] = 16'(cur_i[k]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         mv[k] = -65;
         mu[k] = -13;
      end
      prev_mask = '0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_spike_valid", 32'(spike_valid), 0);
      chk("rst_spike_mask", 32'(spike_mask), 0);
      chk("rst_rd_v", 32'(rd_v), 0);
      chk("rst_rd_u", 32'(rd_u), 0);
   endtask

   task automatic readout_all(input string tag);
      for (int k = 0; k < N; k++) begin
         rd_idx = IW'(k);
         @(posedge clk);
         #1;
         chk({tag, "_rd_v"}, 32'(rd_v), mv[k]);
         chk({tag, "_rd_u"}, 32'(rd_u), mu[k]);
      end
   endtask

   // One full sweep from IDLE with per-cycle checks; optionally rewrites I_bus at cycle chg_cyc
   task automatic run_sweep(input int chg_cyc, input int chg_val);
      int old_v [N];
      int old_u [N];
      int new_v [N];
      int new_u [N];
      bit fired [N];
      logic [N-1:0] m;
      int sel_prev, k, xv, xu;
      m = '0;
      for (int j = 0; j < N; j++) begin
         old_v[j] = mv[j];
         old_u[j] = mu[j];
         model_step(mv[j], mu[j], cur_i[j], new_v[j], new_u[j], fired[j]);
         m[j] = fired[j];
      end
      sel_prev = $urandom_range(N - 1, 0);
      rd_idx   = IW'(sel_prev);
      tick     = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      for (int c = 1; c <= 2 * N + 1; c++) begin
         chk("sw_busy", 32'(busy), int'(c <= 2 * N));
         chk("sw_done", 32'(done), int'(c == 2 * N + 1));
         if ((c % 2 == 0) && (c <= 2 * N)) begin
            k = (c - 2) / 2;
            chk("sw_spike_valid", 32'(spike_valid), int'(fired[k]));
            if (fired[k]) chk("sw_spike_idx", 32'(spike_idx), k);
         end else begin
            chk("sw_spike_valid_idle", 32'(spike_valid), 0);
         end
         // Neuron k's write lands after cycle 2+2k; readout shows the previous cycle's contents
         xv = ((2 + 2 * sel_prev) < (c - 1)) ? new_v[sel_prev] : old_v[sel_prev];
         xu = ((2 + 2 * sel_prev) < (c - 1)) ? new_u[sel_prev] : old_u[sel_prev];
         chk("sw_rd_v", 32'(rd_v), xv);
         chk("sw_rd_u", 32'(rd_u), xu);
         if (c == 2 * N) chk("sw_mask_hold", 32'(spike_mask), 32'(prev_mask));
         if (c == 2 * N + 1) chk("sw_mask", 32'(spike_mask), 32'(m));
         if (c == chg_cyc) begin
            for (int j = 0; j < N; j++) I_bus[16*j +: 16] = 16'(chg_val);
         end
         sel_prev = $urandom_range(N - 1, 0);
         rd_idx   = IW'(sel_prev);
         if (c < 2 * N + 1) begin
            @(posedge clk);
            #1;
         end
      end
      for (int j = 0; j < N; j++) begin
         mv[j] = new_v[j];
         mu[j] = new_u[j];
         if (chg_cyc > 0) cur_i[j] = chg_val;
      end
      prev_mask = m;
      sweep_no++;
      $display("sweep %0d: model mask=%b dut mask=%b", sweep_no, m, spike_mask);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      sweep_no  = 0;
      reset     = 1'b1;
      tick      = 1'b0;
      I_bus     = '0;
      rd_idx    = '0;
      prev_mask = '0;

      //            i_base  hot  i_hot  mask    idx  v       u
      tbl[0] = '{0,      -1,  0,     8'h00,  7,   -68,    -14};
      tbl[1] = '{0,       3,  32767, 8'h08,  3,   -65,    -6};
      tbl[2] = '{32767,  -1,  0,     8'hFF,  5,   -65,    -6};
      tbl[3] = '{-32768, -1,  0,     8'h00,  2,   -32768, -14};
      tbl[4] = '{5,       6,  1000,  8'h40,  0,   -63,    -14};

      // Reset state of every neuron
      do_reset();
      readout_all("reset");

      // Vector table: each entry is one sweep from the reset state
      for (int e = 0; e < 5; e++) begin
         do_reset();
         for (int k = 0; k < N; k++) cur_i[k] = (k == tbl[e].hot) ? tbl[e].i_hot : tbl[e].i_base;
         set_ibus();
         run_sweep(0, 0);
         chk("tbl_mask", 32'(spike_mask), 32'(tbl[e].exp_mask));
         rd_idx = IW'(tbl[e].chk_idx);
         @(posedge clk);
         #1;
         chk("tbl_v", 32'(rd_v), tbl[e].exp_v);
         chk("tbl_u", 32'(rd_u), tbl[e].exp_u);
         readout_all("tbl");
      end

      // Tick held high: back-to-back sweeps every 2N+1 cycles, overrun latched
      do_reset();
      for (int k = 0; k < N; k++) cur_i[k] = 0;
      set_ibus();
      tick = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= 3 * (2 * N + 1); c++) begin
         chk("held_done", 32'(done), int'(c % (2 * N + 1) == 0));
         chk("held_busy", 32'(busy), int'(c % (2 * N + 1) != 0));
         chk("held_overrun", 32'(overrun), int'(c >= 2));
         if (c < 3 * (2 * N + 1)) begin
            @(posedge clk);
            #1;
         end
      end
      tick = 1'b0;
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < N; k++) begin
            int vw, uw;
            bit f;
            model_step(mv[k], mu[k], 0, vw, uw, f);
            mv[k] = vw;
            mu[k] = uw;
         end
      end
      chk("held_mask", 32'(spike_mask), 0);
      readout_all("held");
      chk("held_overrun_sticky", 32'(overrun), 1);
      $display("held-tick sequence: overrun=%0b", overrun);

      // I_bus change mid-sweep has no effect until the next sweep
      do_reset();
      for (int k = 0; k < N; k++) cur_i[k] = 0;
      set_ibus();
      run_sweep(5, 32767);
      chk("mid_mask0", 32'(spike_mask), 0);
      run_sweep(0, 0);
      chk("mid_mask1", 32'(spike_mask), 32'hFF);
      readout_all("mid");

      // Reset during WRITE(4): sweep aborted, no spike, state restored, overrun cleared
      do_reset();
      for (int k = 0; k < N; k++) cur_i[k] = 32767;
      set_ibus();
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (c == 3) tick = 1'b1;
         if (c == 4) tick = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("abort_pre_overrun", 32'(overrun), 1);
      chk("abort_pre_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("abort_spike_gated", 32'(spike_valid), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         mv[k] = -65;
         mu[k] = -13;
      end
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_overrun", 32'(overrun), 0);
      chk("abort_mask", 32'(spike_mask), 0);
      for (int c = 0; c < 20; c++) begin
         chk("abort_no_done", 32'(done), 0);
         @(posedge clk);
         #1;
      end
      readout_all("abort");
      $display("reset-abort sequence complete");

      // Randomized back-to-back sweeps against the reference model
      do_reset();
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(7, 0) == 0) cur_i[k] = int'($urandom_range(40000, 0)) - 20000;
            else cur_i[k] = int'($urandom_range(6000, 0)) - 3000;
         end
         set_ibus();
         run_sweep(0, 0);
      end
      readout_all("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
